// File: rtl/body_marker_overlay_pkg.sv
// rtl/body_marker_overlay_pkg.sv - shared widths, lock-state encoding and marker colours
package body_marker_overlay_pkg;

    localparam int COORD_W  = 11;
    localparam int COLOR_W  = 12;
    localparam int FRAMES_W = 6;

    typedef enum logic [1:0] {
        LOCK_LOST   = 2'd0,
        LOCK_LOCKED = 2'd1,
        LOCK_STALE  = 2'd2
    } lock_state_t;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

    typedef struct packed {
        logic [COORD_W-1:0] lx;
        logic [COORD_W-1:0] ly;
        logic [COORD_W-1:0] hx;
        logic [COORD_W-1:0] hy;
        logic [COORD_W-1:0] rx;
        logic [COORD_W-1:0] ry;
    } coords_t;

    localparam rgb_t COLOR_LEFT  = {12'hFFF, 12'h000, 12'hFFF};
    localparam rgb_t COLOR_HEAD  = {12'h000, 12'hFFF, 12'h000};
    localparam rgb_t COLOR_RIGHT = {12'hFFF, 12'hFFF, 12'h000};
    localparam rgb_t COLOR_GREY  = {12'h800, 12'h800, 12'h800};

endpackage

// File: rtl/body_marker_overlay_marker_hit.sv
// rtl/body_marker_overlay_marker_hit.sv - registered square-outline hit test for one marker
module marker_hit
    import body_marker_overlay_pkg::*;
#(
    parameter int BOX_HALF = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic [COORD_W-1:0] ctr_x,
    input  logic [COORD_W-1:0] ctr_y,
    output logic               hit_q
);

    localparam logic [COORD_W:0] HALF = BOX_HALF[COORD_W:0];

    logic [COORD_W:0] dx, dy, adx, ady;
    logic             hit_d;

    // One extra bit keeps the difference signed, so a centre near 0 clips at the edge
    always_comb begin
        dx    = {1'b0, pix_x} - {1'b0, ctr_x};
        dy    = {1'b0, pix_y} - {1'b0, ctr_y};
        adx   = dx[COORD_W] ? (~dx + 1'b1) : dx;
        ady   = dy[COORD_W] ? (~dy + 1'b1) : dy;
        hit_d = (adx <= HALF) && (ady <= HALF) && ((adx == HALF) || (ady == HALF));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hit_q <= 1'b0;
        else        hit_q <= hit_d;
    end

endmodule

// File: rtl/body_marker_overlay.sv
// rtl/body_marker_overlay.sv - draws lock-aware body markers into the pixel stream; MARKER_BLINK_EN enables stale blinking
module body_marker_overlay
    import body_marker_overlay_pkg::*;
#(
    parameter int BOX_HALF     = 8,
    parameter int STALE_FRAMES = 4,
    parameter int LOST_FRAMES  = 30
`ifdef MARKER_BLINK_EN
    , parameter int BLINK_SHIFT = 3
`endif
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic [COORD_W-1:0]  iX_Cont,
    input  logic [COORD_W-1:0]  iY_Cont,
    input  logic                iDVAL,
    input  logic [COLOR_W-1:0]  iR,
    input  logic [COLOR_W-1:0]  iG,
    input  logic [COLOR_W-1:0]  iB,
    input  logic [COORD_W-1:0]  left_hand_x,
    input  logic [COORD_W-1:0]  left_hand_y,
    input  logic [COORD_W-1:0]  head_x,
    input  logic [COORD_W-1:0]  head_y,
    input  logic [COORD_W-1:0]  right_hand_x,
    input  logic [COORD_W-1:0]  right_hand_y,
    input  logic                coordinates_ready,
    output logic [COLOR_W-1:0]  oR,
    output logic [COLOR_W-1:0]  oG,
    output logic [COLOR_W-1:0]  oB,
    output logic                oDVAL,
    output logic [COORD_W-1:0]  oX_Cont,
    output logic [COORD_W-1:0]  oY_Cont,
    output logic [1:0]          o_lock_state,
    output logic [FRAMES_W-1:0] o_frames_since
);

    localparam logic [FRAMES_W-1:0] STALE_C = STALE_FRAMES[FRAMES_W-1:0];
    localparam logic [FRAMES_W-1:0] LOST_C  = LOST_FRAMES[FRAMES_W-1:0];

    coords_t             in_c;
    coords_t             shadow_q, shadow_d, active_q, active_d;
    logic                ready_prev_q, pending_q, pending_d;
    logic [FRAMES_W-1:0] frames_q, frames_d, frames_out_q;
    logic                cap_edge, fs;
    lock_state_t         lock_q, lock_d;

    logic                dval1_q, dval2_q;
    logic [COORD_W-1:0]  x1_q, y1_q, x2_q, y2_q;
    rgb_t                pix1_q, pix2_q, pix2_d;
    logic                hit_left, hit_head, hit_right;
    logic                show, use_grey;

    // Coordinate capture and frame-boundary hand-over from shadow to active
    always_comb begin
        in_c      = {left_hand_x, left_hand_y, head_x, head_y, right_hand_x, right_hand_y};
        cap_edge  = coordinates_ready && !ready_prev_q;
        fs        = iDVAL && (iX_Cont == '0) && (iY_Cont == '0);
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        frames_d  = frames_q;
        if (cap_edge) begin
            shadow_d  = in_c;
            pending_d = 1'b1;
        end
        if (fs) begin
            if (cap_edge) begin
                active_d  = in_c;
                frames_d  = '0;
                pending_d = 1'b0;
            end else if (pending_q) begin
                active_d  = shadow_q;
                frames_d  = '0;
                pending_d = 1'b0;
            end else if (frames_q < LOST_C) begin
                frames_d  = frames_q + 1'b1;
            end
        end
    end

    always_comb begin
        lock_d = lock_q;
        case (lock_q)
            LOCK_LOCKED: begin
                if (frames_q >= LOST_C)       lock_d = LOCK_LOST;
                else if (frames_q >= STALE_C) lock_d = LOCK_STALE;
            end
            LOCK_STALE: begin
                if (frames_q < STALE_C)       lock_d = LOCK_LOCKED;
                else if (frames_q >= LOST_C)  lock_d = LOCK_LOST;
            end
            LOCK_LOST: begin
                if (frames_q < STALE_C)       lock_d = LOCK_LOCKED;
                else if (frames_q < LOST_C)   lock_d = LOCK_STALE;
            end
            default:                          lock_d = LOCK_LOST;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            ready_prev_q <= 1'b0;
            shadow_q     <= '0;
            active_q     <= '0;
            pending_q    <= 1'b0;
            frames_q     <= LOST_C;
            frames_out_q <= '0;
            lock_q       <= LOCK_LOST;
        end else begin
            ready_prev_q <= coordinates_ready;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            frames_q     <= frames_d;
            frames_out_q <= frames_q;
            lock_q       <= lock_d;
        end
    end

`ifdef MARKER_BLINK_EN
    logic [BLINK_SHIFT:0] blink_q, blink_d;

    always_comb begin
        blink_d  = fs ? blink_q + 1'b1 : blink_q;
        show     = !((lock_q == LOCK_STALE) && blink_q[BLINK_SHIFT]);
        use_grey = 1'b0;
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) blink_q <= '0;
        else       blink_q <= blink_d;
    end
`else
    always_comb begin
        show     = 1'b1;
        use_grey = (lock_q == LOCK_STALE);
    end
`endif

    marker_hit #(.BOX_HALF(BOX_HALF)) u_hit_left (
        .clk(iCLK), .rst_n(iRST), .pix_x(iX_Cont), .pix_y(iY_Cont),
        .ctr_x(active_q.lx), .ctr_y(active_q.ly), .hit_q(hit_left)
    );
    marker_hit #(.BOX_HALF(BOX_HALF)) u_hit_head (
        .clk(iCLK), .rst_n(iRST), .pix_x(iX_Cont), .pix_y(iY_Cont),
        .ctr_x(active_q.hx), .ctr_y(active_q.hy), .hit_q(hit_head)
    );
    marker_hit #(.BOX_HALF(BOX_HALF)) u_hit_right (
        .clk(iCLK), .rst_n(iRST), .pix_x(iX_Cont), .pix_y(iY_Cont),
        .ctr_x(active_q.rx), .ctr_y(active_q.ry), .hit_q(hit_right)
    );

    // Stage 2 colour mux; head wins over left, left over right
    always_comb begin
        pix2_d = pix1_q;
        if (dval1_q && show && (lock_q != LOCK_LOST)) begin
            if (hit_head)       pix2_d = use_grey ? COLOR_GREY : COLOR_HEAD;
            else if (hit_left)  pix2_d = use_grey ? COLOR_GREY : COLOR_LEFT;
            else if (hit_right) pix2_d = use_grey ? COLOR_GREY : COLOR_RIGHT;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            dval1_q <= 1'b0;
            x1_q    <= '0;
            y1_q    <= '0;
            pix1_q  <= '0;
            dval2_q <= 1'b0;
            x2_q    <= '0;
            y2_q    <= '0;
            pix2_q  <= '0;
        end else begin
            dval1_q <= iDVAL;
            x1_q    <= iX_Cont;
            y1_q    <= iY_Cont;
            pix1_q  <= {iR, iG, iB};
            dval2_q <= dval1_q;
            x2_q    <= x1_q;
            y2_q    <= y1_q;
            pix2_q  <= pix2_d;
        end
    end

    assign oR             = pix2_q.r;
    assign oG             = pix2_q.g;
    assign oB             = pix2_q.b;
    assign oDVAL          = dval2_q;
    assign oX_Cont        = x2_q;
    assign oY_Cont        = y2_q;
    assign o_lock_state   = lock_q;
    assign o_frames_since = frames_out_q;

endmodule

// File: tb/tb_body_marker_overlay.sv
// tb/tb_body_marker_overlay.sv - directed self-checking bench for body_marker_overlay
module tb_body_marker_overlay;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] iX = 11'd1, iY = 11'd1;
    logic        iDVAL = 1'b0;
    logic [11:0] iR = '0, iG = '0, iB = '0;
    logic [10:0] lx = '0, ly = '0, hx = '0, hy = '0, rx = '0, ry = '0;
    logic        ready = 1'b0;
    logic [11:0] oR, oG, oB;
    logic        oDVAL;
    logic [10:0] oX, oY;
    logic [1:0]  lock;
    logic [5:0]  fsince;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [10:0] x, y;
        logic [11:0] r, g, b, er, eg, eb;
    } vec_t;

    always #5 clk = ~clk;

    body_marker_overlay dut (
        .iCLK(clk), .iRST(rst_n), .iX_Cont(iX), .iY_Cont(iY), .iDVAL(iDVAL),
        .iR(iR), .iG(iG), .iB(iB),
        .left_hand_x(lx), .left_hand_y(ly), .head_x(hx), .head_y(hy),
        .right_hand_x(rx), .right_hand_y(ry), .coordinates_ready(ready),
        .oR(oR), .oG(oG), .oB(oB), .oDVAL(oDVAL), .oX_Cont(oX), .oY_Cont(oY),
        .o_lock_state(lock), .o_frames_since(fsince)
    );

    task automatic send_pix(input logic [10:0] x, y, input logic [11:0] r, g, b);
        @(negedge clk);
        iX = x; iY = y; iR = r; iG = g; iB = b; iDVAL = 1'b1;
        @(negedge clk);
        iDVAL = 1'b0; iX = 11'd1; iY = 11'd1;
        @(negedge clk);
    endtask

    task automatic do_fs;
        @(negedge clk);
        iX = 11'd0; iY = 11'd0; iDVAL = 1'b1;
        @(negedge clk);
        iDVAL = 1'b0; iX = 11'd1; iY = 11'd1;
        repeat (2) @(negedge clk);
    endtask

    task automatic capture(input logic [10:0] a, b, c, d, e, f);
        @(negedge clk);
        lx = a; ly = b; hx = c; hy = d; rx = e; ry = f; ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({oR, oG, oB, oDVAL, oX, oY, lock, fsince} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h/%h/%h dval=%b (%0d,%0d) lock=%0d frames=%0d, expected all 0",
                     oR, oG, oB, oDVAL, oX, oY, lock, fsince);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (lock !== 2'd0 || fsince !== 6'd30) begin
            n_err++;
            $display("FAIL reset_release: got lock=%0d frames=%0d, expected lock=0 frames=30", lock, fsince);
        end
    endtask

    task automatic test_passthrough;
        send_pix(11'd100, 11'd100, 12'h123, 12'h456, 12'h789);
        n_cmp++;
        if ({oR, oG, oB, oDVAL, oX, oY, lock} !== {12'h123, 12'h456, 12'h789, 1'b1, 11'd100, 11'd100, 2'd0}) begin
            n_err++;
            $display("FAIL passthrough: got %h/%h/%h dval=%b (%0d,%0d) lock=%0d, expected 123/456/789 dval=1 (100,100) lock=0",
                     oR, oG, oB, oDVAL, oX, oY, lock);
        end
    endtask

    task automatic test_locked;
        vec_t v[$];
        capture(11'd600, 11'd400, 11'd320, 11'd240, 11'd700, 11'd400);
        do_fs();
        n_cmp++;
        if (lock !== 2'd1 || fsince !== 6'd0) begin
            n_err++;
            $display("FAIL locked_state: got lock=%0d frames=%0d, expected lock=1 frames=0", lock, fsince);
        end
        v.push_back('{11'd328, 11'd240, 12'h123, 12'h456, 12'h789, 12'h000, 12'hFFF, 12'h000});
        v.push_back('{11'd320, 11'd240, 12'hAAA, 12'hBBB, 12'hCCC, 12'hAAA, 12'hBBB, 12'hCCC});
        v.push_back('{11'd312, 11'd232, 12'h111, 12'h222, 12'h333, 12'h000, 12'hFFF, 12'h000});
        v.push_back('{11'd329, 11'd240, 12'h111, 12'h222, 12'h333, 12'h111, 12'h222, 12'h333});
        v.push_back('{11'd608, 11'd405, 12'h111, 12'h222, 12'h333, 12'hFFF, 12'h000, 12'hFFF});
        v.push_back('{11'd700, 11'd392, 12'h111, 12'h222, 12'h333, 12'hFFF, 12'hFFF, 12'h000});
        foreach (v[i]) begin
            send_pix(v[i].x, v[i].y, v[i].r, v[i].g, v[i].b);
            n_cmp++;
            if ({oR, oG, oB, oDVAL, oX, oY} !== {v[i].er, v[i].eg, v[i].eb, 1'b1, v[i].x, v[i].y}) begin
                n_err++;
                $display("FAIL locked_pix[%0d]: got %h/%h/%h dval=%b (%0d,%0d), expected %h/%h/%h dval=1 (%0d,%0d)",
                         i, oR, oG, oB, oDVAL, oX, oY, v[i].er, v[i].eg, v[i].eb, v[i].x, v[i].y);
            end
        end
    endtask

    task automatic test_overlap;
        vec_t v[$];
        capture(11'd50, 11'd50, 11'd54, 11'd50, 11'd66, 11'd50);
        do_fs();
        v.push_back('{11'd46, 11'd58, 12'h123, 12'h456, 12'h789, 12'h000, 12'hFFF, 12'h000});
        v.push_back('{11'd58, 11'd50, 12'h123, 12'h456, 12'h789, 12'hFFF, 12'h000, 12'hFFF});
        v.push_back('{11'd62, 11'd50, 12'h123, 12'h456, 12'h789, 12'h000, 12'hFFF, 12'h000});
        v.push_back('{11'd74, 11'd50, 12'h123, 12'h456, 12'h789, 12'hFFF, 12'hFFF, 12'h000});
        v.push_back('{11'd54, 11'd50, 12'h123, 12'h456, 12'h789, 12'h123, 12'h456, 12'h789});
        foreach (v[i]) begin
            send_pix(v[i].x, v[i].y, v[i].r, v[i].g, v[i].b);
            n_cmp++;
            if ({oR, oG, oB, oDVAL, oX, oY} !== {v[i].er, v[i].eg, v[i].eb, 1'b1, v[i].x, v[i].y}) begin
                n_err++;
                $display("FAIL overlap_pix[%0d]: got %h/%h/%h dval=%b (%0d,%0d), expected %h/%h/%h dval=1 (%0d,%0d)",
                         i, oR, oG, oB, oDVAL, oX, oY, v[i].er, v[i].eg, v[i].eb, v[i].x, v[i].y);
            end
        end
    endtask

    task automatic test_clip;
        vec_t v[$];
        capture(11'd2, 11'd2, 11'd320, 11'd240, 11'd600, 11'd400);
        do_fs();
        v.push_back('{11'd0,    11'd0,  12'h123, 12'h456, 12'h789, 12'h123, 12'h456, 12'h789});
        v.push_back('{11'd10,   11'd2,  12'h123, 12'h456, 12'h789, 12'hFFF, 12'h000, 12'hFFF});
        v.push_back('{11'd0,    11'd10, 12'h123, 12'h456, 12'h789, 12'hFFF, 12'h000, 12'hFFF});
        v.push_back('{11'd2042, 11'd2,  12'h123, 12'h456, 12'h789, 12'h123, 12'h456, 12'h789});
        v.push_back('{11'd2042, 11'd10, 12'h123, 12'h456, 12'h789, 12'h123, 12'h456, 12'h789});
        foreach (v[i]) begin
            send_pix(v[i].x, v[i].y, v[i].r, v[i].g, v[i].b);
            n_cmp++;
            if ({oR, oG, oB, oDVAL, oX, oY} !== {v[i].er, v[i].eg, v[i].eb, 1'b1, v[i].x, v[i].y}) begin
                n_err++;
                $display("FAIL clip_pix[%0d]: got %h/%h/%h dval=%b (%0d,%0d), expected %h/%h/%h dval=1 (%0d,%0d)",
                         i, oR, oG, oB, oDVAL, oX, oY, v[i].er, v[i].eg, v[i].eb, v[i].x, v[i].y);
            end
        end
    endtask

    task automatic test_lock_aging;
        capture(11'd50, 11'd50, 11'd320, 11'd240, 11'd600, 11'd400);
        do_fs();
        repeat (3) do_fs();
        n_cmp++;
        if (lock !== 2'd1 || fsince !== 6'd3) begin
            n_err++;
            $display("FAIL aging_3: got lock=%0d frames=%0d, expected lock=1 frames=3", lock, fsince);
        end
        do_fs();
        n_cmp++;
        if (lock !== 2'd2 || fsince !== 6'd4) begin
            n_err++;
            $display("FAIL aging_4: got lock=%0d frames=%0d, expected lock=2 frames=4", lock, fsince);
        end
        send_pix(11'd328, 11'd240, 12'h111, 12'h222, 12'h333);
        n_cmp++;
        if ({oR, oG, oB, oDVAL} !== {12'h800, 12'h800, 12'h800, 1'b1}) begin
            n_err++;
            $display("FAIL stale_head: got %h/%h/%h dval=%b, expected 800/800/800 dval=1", oR, oG, oB, oDVAL);
        end
        send_pix(11'd42, 11'd50, 12'h111, 12'h222, 12'h333);
        n_cmp++;
        if ({oR, oG, oB, oDVAL} !== {12'h800, 12'h800, 12'h800, 1'b1}) begin
            n_err++;
            $display("FAIL stale_left: got %h/%h/%h dval=%b, expected 800/800/800 dval=1", oR, oG, oB, oDVAL);
        end
        repeat (25) do_fs();
        n_cmp++;
        if (lock !== 2'd2 || fsince !== 6'd29) begin
            n_err++;
            $display("FAIL aging_29: got lock=%0d frames=%0d, expected lock=2 frames=29", lock, fsince);
        end
        do_fs();
        n_cmp++;
        if (lock !== 2'd0 || fsince !== 6'd30) begin
            n_err++;
            $display("FAIL aging_30: got lock=%0d frames=%0d, expected lock=0 frames=30", lock, fsince);
        end
        send_pix(11'd328, 11'd240, 12'h111, 12'h222, 12'h333);
        n_cmp++;
        if ({oR, oG, oB, oDVAL} !== {12'h111, 12'h222, 12'h333, 1'b1}) begin
            n_err++;
            $display("FAIL lost_pass: got %h/%h/%h dval=%b, expected 111/222/333 dval=1", oR, oG, oB, oDVAL);
        end
        do_fs();
        n_cmp++;
        if (lock !== 2'd0 || fsince !== 6'd30) begin
            n_err++;
            $display("FAIL aging_sat: got lock=%0d frames=%0d, expected lock=0 frames=30", lock, fsince);
        end
    endtask

    task automatic test_same_cycle;
        @(negedge clk);
        lx = 11'd50; ly = 11'd50; hx = 11'd400; hy = 11'd300; rx = 11'd600; ry = 11'd400;
        ready = 1'b1; iX = 11'd0; iY = 11'd0; iDVAL = 1'b1;
        @(negedge clk);
        iDVAL = 1'b0; iX = 11'd1; iY = 11'd1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (lock !== 2'd1 || fsince !== 6'd0) begin
            n_err++;
            $display("FAIL bypass_state: got lock=%0d frames=%0d, expected lock=1 frames=0", lock, fsince);
        end
        send_pix(11'd408, 11'd300, 12'h123, 12'h456, 12'h789);
        n_cmp++;
        if ({oR, oG, oB, oDVAL} !== {12'h000, 12'hFFF, 12'h000, 1'b1}) begin
            n_err++;
            $display("FAIL bypass_head: got %h/%h/%h dval=%b, expected 000/FFF/000 dval=1", oR, oG, oB, oDVAL);
        end
        do_fs();
        n_cmp++;
        if (lock !== 2'd1 || fsince !== 6'd1) begin
            n_err++;
            $display("FAIL held_ready: got lock=%0d frames=%0d, expected lock=1 frames=1", lock, fsince);
        end
        ready = 1'b0;
    endtask

    task automatic test_reset_midframe;
        @(negedge clk);
        iX = 11'd408; iY = 11'd300; iR = 12'h123; iG = 12'h456; iB = 12'h789; iDVAL = 1'b1;
        @(negedge clk);
        iDVAL = 1'b0; iX = 11'd1; iY = 11'd1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({oR, oG, oB, oDVAL, oX, oY, lock, fsince} !== '0) begin
            n_err++;
            $display("FAIL midframe_reset: got %h/%h/%h dval=%b (%0d,%0d) lock=%0d frames=%0d, expected all 0",
                     oR, oG, oB, oDVAL, oX, oY, lock, fsince);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        do_fs();
        n_cmp++;
        if (lock !== 2'd0) begin
            n_err++;
            $display("FAIL post_reset_lock: got lock=%0d, expected 0", lock);
        end
        send_pix(11'd8, 11'd0, 12'h123, 12'h456, 12'h789);
        n_cmp++;
        if ({oR, oG, oB, oDVAL} !== {12'h123, 12'h456, 12'h789, 1'b1}) begin
            n_err++;
            $display("FAIL post_reset_pass: got %h/%h/%h dval=%b, expected 123/456/789 dval=1", oR, oG, oB, oDVAL);
        end
        capture(11'd50, 11'd50, 11'd400, 11'd300, 11'd600, 11'd400);
        do_fs();
        send_pix(11'd408, 11'd300, 12'h123, 12'h456, 12'h789);
        n_cmp++;
        if ({oR, oG, oB, oDVAL, lock} !== {12'h000, 12'hFFF, 12'h000, 1'b1, 2'd1}) begin
            n_err++;
            $display("FAIL relock_head: got %h/%h/%h dval=%b lock=%0d, expected 000/FFF/000 dval=1 lock=1",
                     oR, oG, oB, oDVAL, lock);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_locked();
        test_overlap();
        test_clip();
        test_lock_aging();
        test_same_cycle();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
